// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core sequencing blocks.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [3:0]  REG_PC     = 4'd15;

endpackage

// File: rtl/prio_enc16.sv
// Lowest-set-bit priority encoder over a 16-bit register list.
module prio_enc16 (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        none
);

    // Scan upward and keep the first set bit found.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int unsigned i = 0; i < 16; i++) begin
            if (vec[i] && none) begin
                idx  = 4'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ldm_stm_seq.sv
// Load/store-multiple sequencer: walks a register list lowest-first,
// issuing one word access per set bit, then optionally writes back the base.
module ldm_stm_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_load,
    input  logic        pre,
    input  logic        up,
    input  logic        wback,
    input  logic [3:0]  rn,
    input  logic [31:0] base,
    input  logic [15:0] reglist,
    output logic        busy,
    output logic        done,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  rf_ra,
    input  logic [31:0] rf_rd,
    output logic        rf_we,
    output logic [3:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        pc_we,
    output logic [31:0] pc_wd
);

    import arm_pkg::*;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    seq_state_t  state_q, state_d;
    logic [15:0] list_q,  list_d;
    logic        load_q,  load_d;
    logic        wb_q,    wb_d;
    logic [3:0]  rn_q,    rn_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] fb_q,    fb_d;

    logic [3:0]  cur_idx;
    logic        cur_none;
    logic [15:0] list_clr;
    logic [31:0] span;
    logic [31:0] a0;
    logic [31:0] fb;

    prio_enc16 u_enc (
        .vec  (list_q),
        .idx  (cur_idx),
        .none (cur_none)
    );

    // Start address, final base and per-cycle bookkeeping.
    always_comb begin
        span     = 32'(popcount16(reglist)) * WORD_BYTES;
        fb       = up ? (base + span) : (base - span);
        list_clr = list_q & ~(16'd1 << cur_idx);
        case ({pre, up})
            2'b01:   a0 = base;
            2'b11:   a0 = base + WORD_BYTES;
            2'b00:   a0 = base - span + WORD_BYTES;
            default: a0 = base - span;
        endcase
    end

    // Next-state and output decode for the transfer FSM.
    always_comb begin
        state_d   = state_q;
        list_d    = list_q;
        load_d    = load_q;
        wb_d      = wb_q;
        rn_d      = rn_q;
        addr_d    = addr_q;
        fb_d      = fb_q;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rf_ra     = '0;
        rf_we     = 1'b0;
        rf_wa     = '0;
        rf_wd     = '0;
        pc_we     = 1'b0;
        pc_wd     = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    list_d  = reglist;
                    load_d  = is_load;
                    // A load that reloads the base keeps the loaded value.
                    wb_d    = wback && !(is_load && reglist[rn]);
                    rn_d    = rn;
                    addr_d  = a0;
                    fb_d    = fb;
                    state_d = (reglist == '0) ? DONE : XFER;
                end
            end
            XFER: begin
                mem_valid = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_we    = !load_q;
                if (!load_q) begin
                    rf_ra     = cur_idx;
                    mem_wdata = rf_rd;
                end
                if (cur_none) begin
                    state_d = DONE;
                end else if (mem_ready) begin
                    if (load_q) begin
                        if (cur_idx == REG_PC) begin
                            pc_we = 1'b1;
                            pc_wd = mem_rdata;
                        end else begin
                            rf_we = 1'b1;
                            rf_wa = cur_idx;
                            rf_wd = mem_rdata;
                        end
                    end
                    list_d = list_clr;
                    addr_d = addr_q + WORD_BYTES;
                    if (list_clr == '0) begin
                        state_d = wb_q ? WB : DONE;
                    end
                end
            end
            WB: begin
                rf_we   = 1'b1;
                rf_wa   = rn_q;
                rf_wd   = fb_q;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-operand registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            list_q  <= '0;
            load_q  <= 1'b0;
            wb_q    <= 1'b0;
            rn_q    <= '0;
            addr_q  <= '0;
            fb_q    <= '0;
        end else begin
            state_q <= state_d;
            list_q  <= list_d;
            load_q  <= load_d;
            wb_q    <= wb_d;
            rn_q    <= rn_d;
            addr_q  <= addr_d;
            fb_q    <= fb_d;
        end
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Self-checking bench for ldm_stm_seq: scoreboard of expected memory
// accesses, register-file writes and PC writes.
module tb_ldm_stm_seq;

    logic        clk = 1'b0;
    logic        reset, start, is_load, pre, up, wback;
    logic [3:0]  rn;
    logic [31:0] base;
    logic [15:0] reglist;
    logic        busy, done, mem_valid, mem_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  rf_ra, rf_wa;
    logic [31:0] rf_rd, rf_wd, pc_wd;
    logic        rf_we, pc_we;

    int total = 0;
    int bad   = 0;
    int wait_cfg = 0;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
    typedef struct { logic [3:0] wa; logic [31:0] wd; } rf_exp_t;

    mem_exp_t    exp_mem[$];
    rf_exp_t     exp_rf[$];
    logic [31:0] exp_pc[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rfv(input logic [3:0] i);
        return 32'hCAFE_0000 + ({28'd0, i} * 32'h0000_0111);
    endfunction

    function automatic logic [31:0] memv(input logic [31:0] a);
        return a ^ 32'h5EED_0000;
    endfunction

    assign rf_rd     = rfv(rf_ra);
    assign mem_rdata = memv(mem_addr);

    ldm_stm_seq dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load),
        .pre(pre), .up(up), .wback(wback), .rn(rn), .base(base),
        .reglist(reglist), .busy(busy), .done(done),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we), .rf_wa(rf_wa),
        .rf_wd(rf_wd), .pc_we(pc_we), .pc_wd(pc_wd)
    );

    // Memory ready generator: wait_cfg stall cycles before each acceptance.
    initial begin
        int wcnt;
        wcnt = 0;
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_valid) begin
                wcnt = 0;
                mem_ready = (wait_cfg == 0);
            end else if (wcnt >= wait_cfg) begin
                mem_ready = 1'b1;
                wcnt = 0;
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end
    end

    // Scoreboard consumer: every valid cycle must match the head access.
    initial begin
        mem_exp_t m;
        rf_exp_t  r;
        forever begin
            @(negedge clk);
            if (mem_valid === 1'b1) begin
                total++;
                if (exp_mem.size() == 0) begin
                    bad++;
                    $display("FAIL mem_unexpected got addr=%h we=%b", mem_addr, mem_we);
                end else begin
                    m = exp_mem[0];
                    if (mem_addr !== m.addr || mem_we !== m.we || (m.we && mem_wdata !== m.wdata)) begin
                        bad++;
                        $display("FAIL mem_access got addr=%h we=%b wdata=%h exp addr=%h we=%b wdata=%h",
                                 mem_addr, mem_we, mem_wdata, m.addr, m.we, m.wdata);
                    end
                    if (mem_ready === 1'b1) void'(exp_mem.pop_front());
                end
            end
            if (rf_we === 1'b1) begin
                total++;
                if (exp_rf.size() == 0) begin
                    bad++;
                    $display("FAIL rf_unexpected got wa=%0d wd=%h", rf_wa, rf_wd);
                end else begin
                    r = exp_rf.pop_front();
                    if (rf_wa !== r.wa || rf_wd !== r.wd) begin
                        bad++;
                        $display("FAIL rf_write got wa=%0d wd=%h exp wa=%0d wd=%h", rf_wa, rf_wd, r.wa, r.wd);
                    end
                end
            end
            if (pc_we === 1'b1) begin
                total++;
                if (exp_pc.size() == 0) begin
                    bad++;
                    $display("FAIL pc_unexpected got wd=%h", pc_wd);
                end else if (pc_wd !== exp_pc[0]) begin
                    bad++;
                    $display("FAIL pc_write got wd=%h exp wd=%h", pc_wd, exp_pc.pop_front());
                end else begin
                    void'(exp_pc.pop_front());
                end
            end
        end
    end

    task automatic push_expect(input logic ld, input logic pre_i, input logic up_i,
                               input logic wb_i, input logic [3:0] rn_i,
                               input logic [31:0] base_i, input logic [15:0] rl);
        int unsigned n;
        logic [31:0] a;
        logic [31:0] fbv;
        mem_exp_t    m;
        rf_exp_t     r;
        n = 0;
        for (int i = 0; i < 16; i++) if (rl[i]) n++;
        case ({pre_i, up_i})
            2'b01:   a = base_i;
            2'b11:   a = base_i + 32'd4;
            2'b00:   a = base_i - 32'(4 * n) + 32'd4;
            default: a = base_i - 32'(4 * n);
        endcase
        fbv = up_i ? base_i + 32'(4 * n) : base_i - 32'(4 * n);
        for (int i = 0; i < 16; i++) begin
            if (rl[i]) begin
                m.we    = !ld;
                m.addr  = a;
                m.wdata = ld ? 32'd0 : rfv(4'(i));
                exp_mem.push_back(m);
                if (ld) begin
                    if (i == 15) exp_pc.push_back(memv(a));
                    else begin
                        r.wa = 4'(i);
                        r.wd = memv(a);
                        exp_rf.push_back(r);
                    end
                end
                a = a + 32'd4;
            end
        end
        if (n != 0 && wb_i && !(ld && rl[rn_i])) begin
            r.wa = rn_i;
            r.wd = fbv;
            exp_rf.push_back(r);
        end
    endtask

    // Drives one operation; poke re-raises start (with junk fields) at that cycle.
    task automatic run_op(input logic ld, input logic pre_i, input logic up_i,
                          input logic wb_i, input logic [3:0] rn_i,
                          input logic [31:0] base_i, input logic [15:0] rl,
                          input int poke, output int cyc);
        push_expect(ld, pre_i, up_i, wb_i, rn_i, base_i, rl);
        @(negedge clk);
        is_load = ld; pre = pre_i; up = up_i; wback = wb_i;
        rn = rn_i; base = base_i; reglist = rl; start = 1'b1;
        @(negedge clk);
        cyc = 1;
        start = (poke == 1);
        if (poke == 1) begin reglist = 16'hFFFF; is_load = ~ld; end
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = (cyc == poke);
            if (cyc == poke) begin reglist = 16'hFFFF; is_load = ~ld; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, mem_valid, mem_we, rf_we, pc_we, mem_addr, mem_wdata,
             rf_ra, rf_wa, rf_wd, pc_wd} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b valid=%b addr=%h exp all zero",
                     busy, done, mem_valid, mem_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_stm_ia;
        int cyc;
        wait_cfg = 0;
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h100, 16'h0013, -1, cyc);
        total++;
        if (cyc !== 5) begin bad++; $display("FAIL stm_ia_latency got=%0d exp=5", cyc); end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL stm_ia_busy_in_done got=%b exp=1", busy); end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL stm_ia_idle got done=%b busy=%b exp 0 0", done, busy);
        end
        total++;
        if (exp_mem.size() != 0 || exp_rf.size() != 0) begin
            bad++; $display("FAIL stm_ia_drain got mem=%0d rf=%0d exp 0 0", exp_mem.size(), exp_rf.size());
        end
    endtask

    task automatic test_ldm_db;
        int cyc;
        wait_cfg = 0;
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'h200, 16'h8006, -1, cyc);
        total++;
        if (cyc !== 4) begin bad++; $display("FAIL ldm_db_latency got=%0d exp=4", cyc); end
        @(negedge clk);
        total++;
        if (exp_mem.size() != 0 || exp_rf.size() != 0 || exp_pc.size() != 0) begin
            bad++; $display("FAIL ldm_db_drain got mem=%0d rf=%0d pc=%0d exp 0 0 0",
                            exp_mem.size(), exp_rf.size(), exp_pc.size());
        end
    endtask

    task automatic test_wait_states;
        int cyc;
        wait_cfg = 3;
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 32'h300, 16'h00A0, -1, cyc);
        total++;
        if (cyc !== 10) begin bad++; $display("FAIL wait_ldm_latency got=%0d exp=10", cyc); end
        @(negedge clk);
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h400, 16'h0300, -1, cyc);
        total++;
        if (cyc !== 9) begin bad++; $display("FAIL wait_stm_da_latency got=%0d exp=9", cyc); end
        @(negedge clk);
        total++;
        if (exp_mem.size() != 0 || exp_rf.size() != 0) begin
            bad++; $display("FAIL wait_drain got mem=%0d rf=%0d exp 0 0", exp_mem.size(), exp_rf.size());
        end
        wait_cfg = 0;
    endtask

    task automatic test_wb_suppress;
        int cyc;
        wait_cfg = 0;
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h500, 16'h0004, -1, cyc);
        total++;
        if (cyc !== 2) begin bad++; $display("FAIL wbsup_latency got=%0d exp=2", cyc); end
        @(negedge clk);
        total++;
        if (exp_mem.size() != 0 || exp_rf.size() != 0) begin
            bad++; $display("FAIL wbsup_drain got mem=%0d rf=%0d exp 0 0", exp_mem.size(), exp_rf.size());
        end
    endtask

    task automatic test_empty;
        int cyc;
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 32'h900, 16'h0000, -1, cyc);
        total++;
        if (cyc !== 1) begin bad++; $display("FAIL empty_latency got=%0d exp=1", cyc); end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL empty_idle got done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        wait_cfg = 0;
        push_expect(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 32'h600, 16'h00F0);
        @(negedge clk);
        is_load = 1'b0; pre = 1'b0; up = 1'b1; wback = 1'b1;
        rn = 4'd1; base = 32'h600; reglist = 16'h00F0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({busy, done, mem_valid, mem_we, rf_we, pc_we, mem_addr, mem_wdata,
             rf_ra, rf_wa, rf_wd, pc_wd} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs got busy=%b valid=%b rf_we=%b addr=%h exp all zero",
                     busy, mem_valid, rf_we, mem_addr);
        end
        total++;
        if (exp_mem.size() != 2 || exp_rf.size() != 1) begin
            bad++; $display("FAIL reset_mid_progress got mem=%0d rf=%0d exp 2 1", exp_mem.size(), exp_rf.size());
        end
        exp_mem.delete();
        exp_rf.delete();
        exp_pc.delete();
        run_op(1'b0, 1'b1, 1'b1, 1'b1, 4'd6, 32'h700, 16'h0011, -1, cyc);
        total++;
        if (cyc !== 4) begin bad++; $display("FAIL reset_mid_rerun_latency got=%0d exp=4", cyc); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        wait_cfg = 0;
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 32'h800, 16'h8001, 2, cyc);
        total++;
        if (cyc !== 4) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=4", cyc); end
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 32'hA00, 16'h0C00, -1, cyc);
        total++;
        if (cyc !== 4) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=4", cyc); end
        @(negedge clk);
        total++;
        if (exp_mem.size() != 0 || exp_rf.size() != 0 || exp_pc.size() != 0) begin
            bad++; $display("FAIL b2b_drain got mem=%0d rf=%0d pc=%0d exp 0 0 0",
                            exp_mem.size(), exp_rf.size(), exp_pc.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; is_load = 1'b0; pre = 1'b0; up = 1'b0;
        wback = 1'b0; rn = '0; base = '0; reglist = '0;
        test_reset();
        test_stm_ia();
        test_ldm_db();
        test_wait_states();
        test_wb_suppress();
        test_empty();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
